round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Match-level sequencer downstream of the hit detector. It consumes the per-player hit strobes and owns the scores.
- After each hit it freezes play and clears bullets for a fixed number of frames, then pulses a respawn to the player and bullet blocks.
- Declares a winner at WIN_SCORE and waits for a start press to begin a new match.
- Drives BCD digits for the HEX displays, so the scores show correctly past 9.

Parameters:
- WIN_SCORE, 10, score that ends the match; legal range 1..31.
- FREEZE_FRAMES, 60, frame_tick count spent in FREEZE after a hit; legal range 1..255.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk-cycle strobe per video frame, synchronous to Clk.
- p1_hit  in  1  level: player 1 was struck; player 2 scores.
- p2_hit  in  1  level: player 2 was struck; player 1 scores.
- start  in  1  level, active-high, from a debounced key.
- play_enable  out  1  high while movement and firing are allowed.
- clear_bullets  out  1  high for the whole FREEZE state.
- respawn  out  1  one-cycle pulse; players return to their spawn points.
- p1_score  out  5  binary score of player 1.
- p2_score  out  5  binary score of player 2.
- p1_bcd  out  8  {tens, ones} BCD form of p1_score.
- p2_bcd  out  8  {tens, ones} BCD form of p2_score.
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- All outputs are registered.
- Reset (Reset_n=0, asynchronous) sets:
  - state=PLAY, play_enable=1;
  - scores, BCD digits, winner, freeze counter = 0;
  - clear_bullets=0, respawn=0, game_over=0;
  - edge-detect history registers = 1, so inputs already high at reset release do not count as edges.
- Edge detection: p1_hit, p2_hit and start are each registered once. An event is the cycle where input=1 and its registered copy=0. A held level counts once.
- States: PLAY, FREEZE, RESPAWN, GAME_OVER.
- PLAY:
  - p2_hit edge: p1 score +1. p1_hit edge: p2 score +1. Edges on both in the same cycle: both scores +1.
  - On any hit edge, the next cycle has state=FREEZE, play_enable=0, clear_bullets=1, freeze counter=0 and the updated scores. Latency from edge to visible score is 1 Clk.
  - A frame_tick in the same cycle as a hit edge is not counted.
- FREEZE:
  - Each frame_tick increments the counter.
  - When the counter reaches FREEZE_FRAMES-1 and a tick arrives:
    - if either score == WIN_SCORE: go to GAME_OVER and set winner (11 if both reached it);
    - otherwise go to RESPAWN.
  - Hit edges are ignored in FREEZE.
- RESPAWN: lasts exactly 1 cycle with respawn=1, clear_bullets=0, play_enable=0. Next state is PLAY with play_enable=1.
- GAME_OVER:
  - game_over=1, play_enable=0, clear_bullets=1; scores and winner hold.
  - A start edge clears scores, BCD digits and winner, then goes to RESPAWN.
- A start edge outside GAME_OVER is ignored.
- Scores never exceed WIN_SCORE, because any increment to WIN_SCORE ends the match.
- BCD counters increment together with the binary score: ones digit 9 to 0 with tens +1. Range is 00..31. No combinational division.
- Reset asserted mid-FREEZE or mid-RESPAWN aborts immediately to the reset state. No respawn pulse is emitted.

Decomposition:
- Shared package game_pkg holds:
  - round_state_t enum {PLAY, FREEZE, RESPAWN, GAME_OVER};
  - winner encoding constants WIN_NONE, WIN_P1, WIN_P2, WIN_TIE;
  - SCORE_W=5.
- One sub-module: bcd_score_counter. It has inc and clr inputs and keeps the binary and two-digit BCD values in lockstep. It is instantiated once per player.

Test Plan:
- Reset release, then p2_hit held high for 5 cycles:
  - p1_score=1 and p1_bcd=8'h01 one cycle after the edge, counted once;
  - FREEZE with clear_bullets=1;
  - after 60 frame_ticks, respawn high for 1 cycle, then play_enable=1.
- p1_hit and p2_hit edges in the same cycle: both scores=1, single FREEZE, winner stays 00.
- Drive p1 to 9 and then one more hit: p1_bcd=8'h10, p1_score=5'd10. After the freeze, game_over=1, winner=01, respawn not pulsed.
- WIN_SCORE=3 with both players at 2, then simultaneous hit edges: winner=11 after the freeze.
- start pressed in PLAY: no effect. start pressed in GAME_OVER: scores=0, winner=00, one respawn pulse, then PLAY.
- Reset_n pulsed low at FREEZE tick 30: outputs return to reset values immediately, and no respawn pulse follows. Also check that a frame_tick coincident with the hit edge does not shorten the freeze (still 60 ticks).

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the match-level game logic.
package game_pkg;

  localparam int unsigned SCORE_W  = 5;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned FREEZE_W = 8;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    FREEZE    = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } round_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Two-digit BCD score as shown on a pair of HEX displays.
  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  function automatic logic [1:0] winner_code(input logic p1_won, input logic p2_won);
    logic [1:0] code;
    case ({p2_won, p1_won})
      2'b01:   code = WIN_P1;
      2'b10:   code = WIN_P2;
      2'b11:   code = WIN_TIE;
      default: code = WIN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Score counter holding binary and two-digit BCD forms in lockstep.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [SCORE_W-1:0] score,
  output bcd2_t              bcd
);

  // BCD carries ripple digit-by-digit so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score    <= '0;
      bcd.tens <= '0;
      bcd.ones <= '0;
    end else if (clr) begin
      score    <= '0;
      bcd.tens <= '0;
      bcd.ones <= '0;
    end else if (inc) begin
      score <= score + SCORE_W'(1);
      if (bcd.ones == DIGIT_W'(9)) begin
        bcd.ones <= '0;
        bcd.tens <= bcd.tens + DIGIT_W'(1);
      end else begin
        bcd.ones <= bcd.ones + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Match sequencer: scores hits, freezes play, respawns players and declares the winner.
module round_controller
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 10,
  parameter int unsigned FREEZE_FRAMES = 60
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               p1_hit,
  input  logic               p2_hit,
  input  logic               start,
  output logic               play_enable,
  output logic               clear_bullets,
  output logic               respawn,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         p1_bcd,
  output logic [7:0]         p2_bcd,
  output logic [1:0]         winner,
  output logic               game_over
);

  localparam logic [SCORE_W-1:0]  WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [FREEZE_W-1:0] LAST_FRAME = FREEZE_W'(FREEZE_FRAMES - 1);

  round_state_t        state, state_d;
  logic [FREEZE_W-1:0] freeze_cnt, freeze_cnt_d;
  logic [1:0]          winner_d;
  logic                p1_q, p2_q, start_q;
  logic                p1_edge, p2_edge, start_edge;
  logic                p1_inc, p2_inc, score_clr;
  logic                p1_won, p2_won;
  bcd2_t               p1_bcd_s, p2_bcd_s;

  assign p1_edge    = p1_hit & ~p1_q;
  assign p2_edge    = p2_hit & ~p2_q;
  assign start_edge = start & ~start_q;
  assign p1_won     = (p1_score == WIN_VAL);
  assign p2_won     = (p2_score == WIN_VAL);
  assign p1_bcd     = p1_bcd_s;
  assign p2_bcd     = p2_bcd_s;

  bcd_score_counter u_p1_score (
    .clk   (Clk),
    .rst_n (Reset_n),
    .inc   (p1_inc),
    .clr   (score_clr),
    .score (p1_score),
    .bcd   (p1_bcd_s)
  );

  bcd_score_counter u_p2_score (
    .clk   (Clk),
    .rst_n (Reset_n),
    .inc   (p2_inc),
    .clr   (score_clr),
    .score (p2_score),
    .bcd   (p2_bcd_s)
  );

  // Next-state logic; score counters are steered from here.
  always_comb begin
    state_d      = state;
    freeze_cnt_d = freeze_cnt;
    winner_d     = winner;
    p1_inc       = 1'b0;
    p2_inc       = 1'b0;
    score_clr    = 1'b0;
    case (state)
      PLAY: begin
        if (p1_edge || p2_edge) begin
          p1_inc       = p2_edge;
          p2_inc       = p1_edge;
          freeze_cnt_d = '0;
          state_d      = FREEZE;
        end
      end
      FREEZE: begin
        if (frame_tick) begin
          if (freeze_cnt == LAST_FRAME) begin
            if (p1_won || p2_won) begin
              state_d  = GAME_OVER;
              winner_d = winner_code(p1_won, p2_won);
            end else begin
              state_d = RESPAWN;
            end
          end else begin
            freeze_cnt_d = freeze_cnt + FREEZE_W'(1);
          end
        end
      end
      RESPAWN: state_d = PLAY;
      GAME_OVER: begin
        if (start_edge) begin
          score_clr = 1'b1;
          winner_d  = WIN_NONE;
          state_d   = RESPAWN;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // State, edge history and outputs decoded from the next state so they align with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= PLAY;
      freeze_cnt    <= '0;
      winner        <= WIN_NONE;
      p1_q          <= 1'b1;
      p2_q          <= 1'b1;
      start_q       <= 1'b1;
      play_enable   <= 1'b1;
      clear_bullets <= 1'b0;
      respawn       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_d;
      freeze_cnt    <= freeze_cnt_d;
      winner        <= winner_d;
      p1_q          <= p1_hit;
      p2_q          <= p2_hit;
      start_q       <= start;
      play_enable   <= (state_d == PLAY);
      clear_bullets <= (state_d == FREEZE) || (state_d == GAME_OVER);
      respawn       <= (state_d == RESPAWN);
      game_over     <= (state_d == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed-plus-random bench for round_controller against a score/phase model.
module tb_round_controller;

  localparam int FRAMES = 60;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_tick, p1_hit, p2_hit, start;
  logic       play_enable, clear_bullets, respawn, game_over;
  logic [4:0] p1_score, p2_score;
  logic [7:0] p1_bcd, p2_bcd;
  logic [1:0] winner;

  logic       rst3_n, tick3, h1_3, h2_3, start3;
  logic       pe3, cb3, rsp3, go3;
  logic [4:0] s1_3, s2_3;
  logic [7:0] b1_3, b2_3;
  logic [1:0] w3;

  int n_checks = 0;
  int n_fail   = 0;
  int m1 = 0;
  int m2 = 0;

  always #10 Clk = ~Clk;

  round_controller #(.WIN_SCORE(10), .FREEZE_FRAMES(FRAMES)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .p1_hit(p1_hit),
    .p2_hit(p2_hit), .start(start), .play_enable(play_enable),
    .clear_bullets(clear_bullets), .respawn(respawn), .p1_score(p1_score),
    .p2_score(p2_score), .p1_bcd(p1_bcd), .p2_bcd(p2_bcd), .winner(winner),
    .game_over(game_over)
  );

  round_controller #(.WIN_SCORE(3), .FREEZE_FRAMES(2)) dut3 (
    .Clk(Clk), .Reset_n(rst3_n), .frame_tick(tick3), .p1_hit(h1_3),
    .p2_hit(h2_3), .start(start3), .play_enable(pe3),
    .clear_bullets(cb3), .respawn(rsp3), .p1_score(s1_3),
    .p2_score(s2_3), .p1_bcd(b1_3), .p2_bcd(b2_3), .winner(w3),
    .game_over(go3)
  );

  function automatic int exp_bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_p1_score"}, 32'(p1_score), m1);
    check({tag, "_p2_score"}, 32'(p2_score), m2);
    check({tag, "_p1_bcd"}, 32'(p1_bcd), exp_bcd(m1));
    check({tag, "_p2_bcd"}, 32'(p2_bcd), exp_bcd(m2));
  endtask

  // Hit edge in PLAY, optionally held for extra cycles; scores must move exactly once.
  task automatic hit(input logic h1, input logic h2, input logic tick, input int hold);
    p1_hit = h1; p2_hit = h2; frame_tick = tick;
    step();
    if (h2) m1++;
    if (h1) m2++;
    frame_tick = 1'b0;
    check_scores("hit");
    check("hit_clear_bullets", 32'(clear_bullets), 1);
    check("hit_play_enable", 32'(play_enable), 0);
    repeat (hold) begin
      step();
      check("hold_p1_score", 32'(p1_score), m1);
      check("hold_p2_score", 32'(p2_score), m2);
    end
    p1_hit = 1'b0; p2_hit = 1'b0;
    step();
  endtask

  // Deliver FRAMES ticks with random gaps and stray hit pulses, then check the exit.
  task automatic run_freeze(input logic expect_over, input int exp_win);
    for (int t = 1; t <= FRAMES; t++) begin
      repeat ($urandom_range(0, 2)) begin
        p1_hit = 1'($urandom_range(0, 1));
        step();
      end
      p1_hit = 1'b0;
      if (t == FRAMES) begin
        check("pre_last_tick_clear", 32'(clear_bullets), 1);
        check("pre_last_tick_respawn", 32'(respawn), 0);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
    check_scores("freeze_exit");
    if (expect_over) begin
      check("over_game_over", 32'(game_over), 1);
      check("over_winner", 32'(winner), exp_win);
      check("over_play_enable", 32'(play_enable), 0);
      check("over_clear_bullets", 32'(clear_bullets), 1);
      check("over_respawn", 32'(respawn), 0);
      step();
      check("over_respawn_next", 32'(respawn), 0);
      check("over_hold", 32'(game_over), 1);
    end else begin
      check("respawn_pulse", 32'(respawn), 1);
      check("respawn_clear", 32'(clear_bullets), 0);
      check("respawn_play_enable", 32'(play_enable), 0);
      step();
      check("respawn_end", 32'(respawn), 0);
      check("play_resumed", 32'(play_enable), 1);
      check("winner_none", 32'(winner), 0);
    end
  endtask

  // Idle PLAY cycles with random ticks and start presses, both of which must be ignored.
  task automatic play_idle();
    repeat ($urandom_range(1, 6)) begin
      frame_tick = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      step();
      check("idle_play_enable", 32'(play_enable), 1);
      check("idle_respawn", 32'(respawn), 0);
      check("idle_p1_score", 32'(p1_score), m1);
    end
    frame_tick = 1'b0;
    start      = 1'b0;
    step();
  endtask

  // One round on the WIN_SCORE=3, FREEZE_FRAMES=2 instance.
  task automatic round3(input int exp_s, input logic expect_over, input int exp_win);
    h1_3 = 1'b1; h2_3 = 1'b1;
    step();
    h1_3 = 1'b0; h2_3 = 1'b0;
    check("w3_p1_score", 32'(s1_3), exp_s);
    check("w3_p2_score", 32'(s2_3), exp_s);
    check("w3_clear", 32'(cb3), 1);
    step();
    repeat (2) begin
      tick3 = 1'b1;
      step();
      tick3 = 1'b0;
      step();
    end
    if (expect_over) begin
      check("w3_game_over", 32'(go3), 1);
      check("w3_winner", 32'(w3), exp_win);
    end else begin
      check("w3_play", 32'(pe3), 1);
      check("w3_winner_none", 32'(w3), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    Reset_n = 1'b0; frame_tick = 1'b0; p1_hit = 1'b0; p2_hit = 1'b1; start = 1'b0;
    rst3_n = 1'b0; tick3 = 1'b0; h1_3 = 1'b0; h2_3 = 1'b0; start3 = 1'b0;
    repeat (3) step();
    check("rst_play_enable", 32'(play_enable), 1);
    check("rst_clear", 32'(clear_bullets), 0);
    check("rst_respawn", 32'(respawn), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_winner", 32'(winner), 0);
    check_scores("rst");

    Reset_n = 1'b1; rst3_n = 1'b1;
    repeat (3) step();
    check("held_at_release_p1", 32'(p1_score), 0);
    check("held_at_release_play", 32'(play_enable), 1);
    p2_hit = 1'b0;
    step();

    // Held hit counts once; coincident tick does not shorten the freeze.
    hit(1'b0, 1'b1, 1'b1, 4);
    check("first_bcd", 32'(p1_bcd), 32'h01);
    run_freeze(1'b0, 0);

    hit(1'b1, 1'b1, 1'b0, 0);
    check("both_winner", 32'(winner), 0);
    run_freeze(1'b0, 0);

    while (m1 < 9) begin
      play_idle();
      r = int'($urandom_range(0, 2));
      if (r == 1 && m2 < 8)      hit(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 3)));
      else if (r == 2 && m2 < 8) hit(1'b1, 1'b1, 1'b0, 0);
      else                       hit(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 3)));
      if (m1 < 10) run_freeze(1'b0, 0);
    end
    check("nine_bcd", 32'(p1_bcd), 32'h09);

    hit(1'b0, 1'b1, 1'b0, 0);
    check("ten_bcd", 32'(p1_bcd), 32'h10);
    check("ten_score", 32'(p1_score), 10);
    run_freeze(1'b1, 1);

    p2_hit = 1'b1; step(); p2_hit = 1'b0; step();
    check("over_ignores_hit", 32'(p1_score), 10);
    check("over_still", 32'(game_over), 1);

    start = 1'b1;
    step();
    m1 = 0; m2 = 0;
    check_scores("restart");
    check("restart_winner", 32'(winner), 0);
    check("restart_respawn", 32'(respawn), 1);
    check("restart_game_over", 32'(game_over), 0);
    step();
    check("restart_respawn_end", 32'(respawn), 0);
    check("restart_play", 32'(play_enable), 1);
    start = 1'b0;
    step();

    // Asynchronous reset in the middle of a freeze.
    hit(1'b0, 1'b1, 1'b0, 0);
    for (int t = 0; t < 30; t++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
    check("mid_freeze_clear", 32'(clear_bullets), 1);
    #3 Reset_n = 1'b0;
    #2;
    m1 = 0; m2 = 0;
    check("abort_play_enable", 32'(play_enable), 1);
    check("abort_clear", 32'(clear_bullets), 0);
    check("abort_respawn", 32'(respawn), 0);
    check("abort_game_over", 32'(game_over), 0);
    check_scores("abort");
    step();
    Reset_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      frame_tick = 1'(c % 2);
      step();
      check("post_abort_no_respawn", 32'(respawn), 0);
    end
    frame_tick = 1'b0;

    round3(1, 1'b0, 0);
    round3(2, 1'b0, 0);
    round3(3, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
